// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID pipeline register, 32x32 register file with write-through
// bypass, field/immediate decode, load-use stall detection and ECALL detection.
module id_stage #(
    parameter logic [31:0] NOP_INST   = 32'h0000_0033,
    parameter logic [31:0] ECALL_INST = 32'h0000_0073
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   if_id_bus_in,
    input  logic          flush,
    input  logic          exe_valid,
    input  logic          exe_is_load,
    input  logic [4:0]    exe_rd,
    input  logic          wb_we,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_data,
    output logic          stall_flag,
    output logic          ecall_flag,
    output logic [144:0]  id_exe_bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic        v_r;
    logic [31:0] inst_r;
    logic [31:0] pc_r;
    logic [31:0] rf_r [32];

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic        funct7b5_s;
    logic [31:0] imm_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic        uses_rs1_s;
    logic        uses_rs2_s;
    logic        stall_s;
    logic        valid_s;

    assign opcode_s   = inst_r[6:0];
    assign rd_s       = inst_r[11:7];
    assign funct3_s   = inst_r[14:12];
    assign rs1_s      = inst_r[19:15];
    assign rs2_s      = inst_r[24:20];
    assign funct7b5_s = inst_r[30];

    // IF/ID register: flush beats stall, stall holds the captured instruction
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_r    <= 1'b0;
            inst_r <= NOP_INST;
            pc_r   <= 32'h0000_0000;
        end else if (stall_s) begin
            v_r    <= v_r;
            inst_r <= inst_r;
            pc_r   <= pc_r;
        end else begin
            v_r    <= 1'b1;
            inst_r <= if_id_bus_in[63:32];
            pc_r   <= if_id_bus_in[31:0];
        end
    end

    // Register file storage; entry 0 stays zero because it is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'h0000_0000;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf_r[wb_rd] <= wb_data;
        end
    end

    // Register reads with same-cycle writeback bypass
    always_comb begin
        rs1_val_s = 32'h0000_0000;
        rs2_val_s = 32'h0000_0000;
        if (rs1_s == 5'd0) begin
            rs1_val_s = 32'h0000_0000;
        end else if (wb_we && (wb_rd == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_r[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rs2_val_s = 32'h0000_0000;
        end else if (wb_we && (wb_rd == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_r[rs2_s];
        end
    end

    // Immediate generation and source-register usage by format
    always_comb begin
        imm_s      = 32'h0000_0000;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b0;
        case (opcode_s)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm_s = {{20{inst_r[31]}}, inst_r[31:20]};
            OP_STORE: begin
                imm_s      = {{20{inst_r[31]}}, inst_r[31:25], inst_r[11:7]};
                uses_rs2_s = 1'b1;
            end
            OP_BRANCH: begin
                imm_s      = {{20{inst_r[31]}}, inst_r[7], inst_r[30:25], inst_r[11:8], 1'b0};
                uses_rs2_s = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_s      = {inst_r[31:12], 12'h000};
                uses_rs1_s = 1'b0;
            end
            OP_JAL: begin
                imm_s      = {{12{inst_r[31]}}, inst_r[19:12], inst_r[20], inst_r[30:21], 1'b0};
                uses_rs1_s = 1'b0;
            end
            OP_REG:
                uses_rs2_s = 1'b1;
            default:
                imm_s = 32'h0000_0000;
        endcase
    end

    // Load-use hazard against the instruction now in execute
    always_comb begin
        stall_s = 1'b0;
        if (v_r && !flush && exe_valid && exe_is_load && (exe_rd != 5'd0)) begin
            stall_s = (uses_rs1_s && (rs1_s == exe_rd)) || (uses_rs2_s && (rs2_s == exe_rd));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign valid_s    = v_r && !stall_s && !flush;
    assign stall_flag = stall_s;
    assign ecall_flag = valid_s && (inst_r == ECALL_INST);

    // Decoded bundle; a bubble carries only the NOP opcode
    always_comb begin
        id_exe_bus = {1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, OP_REG, 3'd0, 1'b0};
        if (valid_s) begin
            id_exe_bus = {1'b1, pc_r, rs1_val_s, rs2_val_s, imm_s, rd_s, opcode_s, funct3_s, funct7b5_s};
        end else begin
            id_exe_bus = {1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, OP_REG, 3'd0, 1'b0};
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: stimulus pushes hand-computed expectations into a
// queue; a negedge monitor pops and compares them against the live outputs.
module tb_id_stage;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   if_id_bus_in;
    logic          flush;
    logic          exe_valid;
    logic          exe_is_load;
    logic [4:0]    exe_rd;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          stall_flag;
    logic          ecall_flag;
    logic [144:0]  id_exe_bus;

    id_stage dut (
        .clk(clk), .rst(rst), .if_id_bus_in(if_id_bus_in), .flush(flush),
        .exe_valid(exe_valid), .exe_is_load(exe_is_load), .exe_rd(exe_rd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_flag(stall_flag), .ecall_flag(ecall_flag), .id_exe_bus(id_exe_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [144:0] bus;
        logic         stall;
        logic         ecall;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD311 = 32'h0010_81B3; // add x3,x1,x1
    localparam logic [31:0] I_ADD310 = 32'h0000_81B3; // add x3,x1,x0
    localparam logic [31:0] I_ADD420 = 32'h0001_0233; // add x4,x2,x0
    localparam logic [31:0] I_LUI    = 32'h0001_0137; // lui x2,0x10 (rs1 field = 2)
    localparam logic [31:0] I_ECALL  = 32'h0000_0073;
    localparam logic [31:0] I_BEQ    = 32'hFE00_0EE3; // beq x0,x0,-4
    localparam logic [31:0] I_JAL    = 32'h0010_00EF; // jal x1,2048
    localparam logic [31:0] I_SW     = 32'hFE11_2FA3; // sw x1,-1(x2)

    function automatic logic [144:0] mk(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        return {v, pc, r1, r2, imm, rd, opc, f3, f7};
    endfunction

    function automatic logic [144:0] bubble();
        return mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 7'b0110011, 3'd0, 1'b0);
    endfunction

    task automatic push(input logic [144:0] bus, input logic stall, input logic ecall, input string name);
        exp_t e;
        e.bus = bus; e.stall = stall; e.ecall = ecall; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the expectation issued for this cycle away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (id_exe_bus !== e.bus) begin
                n_fail++;
                $display("FAIL %s bus: got %h expected %h", e.name, id_exe_bus, e.bus);
            end
            n_checks++;
            if (stall_flag !== e.stall) begin
                n_fail++;
                $display("FAIL %s stall_flag: got %b expected %b", e.name, stall_flag, e.stall);
            end
            n_checks++;
            if (ecall_flag !== e.ecall) begin
                n_fail++;
                $display("FAIL %s ecall_flag: got %b expected %b", e.name, ecall_flag, e.ecall);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; exe_valid = 1'b0; exe_is_load = 1'b0; exe_rd = 5'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; if_id_bus_in = 64'h0;
        repeat (2) tick();

        // A: reset state
        rst = 1'b0; if_id_bus_in = {I_ADDI, 32'h0000_0000};
        push(bubble(), 1'b0, 1'b0, "reset");
        tick();
        // B: addi decoded; load in execute targets x5 (addi's unused rs2 field) -> no stall
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd5;
        if_id_bus_in = {I_ADD311, 32'h0000_0004};
        push(mk(1'b1, 32'h0, 32'h0, 32'h0, 32'h5, 5'd1, 7'b0010011, 3'd0, 1'b0), 1'b0, 1'b0, "addi");
        tick();
        // C: writeback x1 bypassed into both operands
        exe_valid = 1'b0; exe_is_load = 1'b0; exe_rd = 5'd0;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
        if_id_bus_in = {I_ADD310, 32'h0000_0008};
        push(mk(1'b1, 32'h4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 5'd3, 7'b0110011, 3'd0, 1'b0), 1'b0, 1'b0, "bypass");
        tick();
        // D: x1 from storage, write to x0 not visible
        wb_rd = 5'd0; wb_data = 32'h0000_1234;
        if_id_bus_in = {I_ADD420, 32'h0000_000C};
        push(mk(1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd3, 7'b0110011, 3'd0, 1'b0), 1'b0, 1'b0, "x0_write");
        tick();
        // E: load-use on x2 -> stall, bubble
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd2;
        if_id_bus_in = {I_LUI, 32'h0000_0010};
        push(bubble(), 1'b1, 1'b0, "load_use");
        tick();
        // F: held instruction issues
        exe_valid = 1'b0; exe_is_load = 1'b0; exe_rd = 5'd0;
        push(mk(1'b1, 32'hC, 32'h0, 32'h0, 32'h0, 5'd4, 7'b0110011, 3'd0, 1'b0), 1'b0, 1'b0, "after_stall");
        tick();
        // G: lui's rs1 field matches load rd, but lui has no rs1 -> no stall
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd2;
        if_id_bus_in = {I_ADD420, 32'h0000_0014};
        push(mk(1'b1, 32'h10, 32'h0, 32'h0, 32'h0001_0000, 5'd2, 7'b0110111, 3'd0, 1'b0), 1'b0, 1'b0, "lui_nostall");
        tick();
        // H: hazard plus flush -> flush wins
        flush = 1'b1;
        if_id_bus_in = {I_ECALL, 32'h0000_0018};
        push(bubble(), 1'b0, 1'b0, "stall_flush");
        tick();
        // I: IF/ID cleared by flush
        flush = 1'b0; exe_valid = 1'b0; exe_is_load = 1'b0; exe_rd = 5'd0;
        if_id_bus_in = {I_ECALL, 32'h0000_001C};
        push(bubble(), 1'b0, 1'b0, "post_flush");
        tick();
        // J: ecall decoded
        if_id_bus_in = {I_ECALL, 32'h0000_0020};
        push(mk(1'b1, 32'h1C, 32'h0, 32'h0, 32'h0, 5'd0, 7'b1110011, 3'd0, 1'b0), 1'b0, 1'b1, "ecall");
        tick();
        // K: ecall with flush suppressed
        flush = 1'b1;
        if_id_bus_in = {I_BEQ, 32'h0000_0024};
        push(bubble(), 1'b0, 1'b0, "ecall_flush");
        tick();
        // L: bubble after flush
        flush = 1'b0;
        push(bubble(), 1'b0, 1'b0, "post_flush2");
        tick();
        // M: beq immediate
        if_id_bus_in = {I_JAL, 32'h0000_0028};
        push(mk(1'b1, 32'h24, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd29, 7'b1100011, 3'd0, 1'b1), 1'b0, 1'b0, "beq_imm");
        tick();
        // N: jal immediate (rs2 field = x1)
        if_id_bus_in = {I_SW, 32'h0000_002C};
        push(mk(1'b1, 32'h28, 32'h0, 32'hDEAD_BEEF, 32'h0000_0800, 5'd1, 7'b1101111, 3'd0, 1'b0), 1'b0, 1'b0, "jal_imm");
        tick();
        // O: sw immediate
        if_id_bus_in = {I_ADD420, 32'h0000_0030};
        push(mk(1'b1, 32'h2C, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd31, 7'b0100011, 3'd2, 1'b1), 1'b0, 1'b0, "sw_imm");
        tick();
        // P: reset during a stall
        rst = 1'b1; exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd2;
        if_id_bus_in = {I_ADD311, 32'h0000_0034};
        push(bubble(), 1'b1, 1'b0, "rst_stall");
        tick();
        // Q: cleared after reset
        rst = 1'b0; exe_valid = 1'b0; exe_is_load = 1'b0; exe_rd = 5'd0;
        push(bubble(), 1'b0, 1'b0, "post_rst");
        tick();
        // R: register file zeroed by reset
        push(mk(1'b1, 32'h34, 32'h0, 32'h0, 32'h0, 5'd3, 7'b0110011, 3'd0, 1'b0), 1'b0, 1'b0, "rf_cleared");
        tick();

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RISC-V (RV32I) core, directly downstream of the fetch stage. It captures the fetch stage's 64-bit `{inst, pc}` bus into the IF/ID pipeline register and holds the 32×32 integer register file with write-through bypass. It decodes fields and immediates and presents the decoded bundle to the execute stage. It also raises the load-use `stall_flag` and the `ecall_flag` consumed by fetch.

## Interface
- `NOP_INST`, default 32'h0000_0033, bubble instruction (ADD x0,x0,x0).
- `ECALL_INST`, default 32'h0000_0073, ECALL encoding.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_id_bus_in`  in  64  `[63:32]` instruction (big-endian-corrected), `[31:0]` pc.
- `flush`  in  1  branch/jump taken in execute (`br_flag|jmp_flag`).
- `exe_valid`  in  1  execute stage holds a real instruction.
- `exe_is_load`  in  1  that instruction is a load.
- `exe_rd`  in  5  its destination register.
- `wb_we`  in  1  writeback enable.
- `wb_rd`  in  5  writeback register.
- `wb_data`  in  32  writeback data.
- `stall_flag`  out  1  hold fetch PC and IF/ID.
- `ecall_flag`  out  1  ECALL in decode; fetch redirects to CSR vector.
- `id_exe_bus`  out  145  decoded bundle, layout below.

## Operation
- IF/ID register `{v, inst, pc}`. Its next value is chosen in this priority order:
  - `rst`: `{0, NOP_INST, 0}`.
  - `flush`: `{0, NOP_INST, 0}`. Flush overrides stall.
  - `stall_flag`: hold.
  - Otherwise: `{1, if_id_bus_in}`.
- Fields: opcode=inst[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7b5=inst[30].
- Immediates (sign bit inst[31]), selected by opcode:
  - I (0000011, 0010011, 1100111, 1110011): sext(inst[31:20]).
  - S (0100011): sext({[31:25],[11:7]}).
  - B (1100011): sext({[31],[7],[30:25],[11:8],0}).
  - U (0110111, 0010111): {[31:12],12'b0}.
  - J (1101111): sext({[31],[19:12],[20],[30:21],0}).
  - Any other opcode: 0.
- Register file:
  - x0 reads 0 and is never written.
  - Write on a rising edge when `wb_we && wb_rd!=0`.
  - Read bypass: if `wb_we && wb_rd!=0 && wb_rd==rsN`, the read returns `wb_data` in the same cycle.
- Source usage:
  - uses_rs1 = opcode not in {0110111, 0010111, 1101111}.
  - uses_rs2 = opcode in {0110011, 0100011, 1100011}.
- Load-use hazard, combinational: `stall_flag = v && !flush && exe_valid && exe_is_load && exe_rd!=0 && ((uses_rs1 && rs1==exe_rd) || (uses_rs2 && rs2==exe_rd))`.
- ECALL: `ecall_flag = v && !flush && !stall_flag && inst==ECALL_INST`.
- `id_exe_bus` bit ranges:
  - [144] valid
  - [143:112] pc
  - [111:80] rs1_val
  - [79:48] rs2_val
  - [47:16] imm
  - [15:11] rd
  - [10:4] opcode
  - [3:1] funct3
  - [0] funct7b5
- valid = `v && !stall_flag && !flush`. When valid=0 the bundle is a bubble: every other field is driven to 0 except opcode, which is 0110011 (NOP).

## Timing
- Latency: an instruction on `if_id_bus_in` at edge N appears on `id_exe_bus` during cycle N+1, combinationally from IF/ID.
- All outputs are combinational from the IF/ID register, the register file and the inputs; there are no output registers.
- After reset: `id_exe_bus` is a bubble, `stall_flag=0`, `ecall_flag=0`, all registers read 0.
- Stall lasts exactly one cycle per load-use: on the next cycle the load has left execute.
- Stall combined with flush: flush wins; IF/ID is cleared and `stall_flag` is deasserted.
- A write and a read of the same register in the same cycle returns the new data.
- Reset mid-stall: IF/ID is cleared on that edge and the register file is zeroed. The register file reset is synchronous, all 32 entries.

## Test plan
- Reset, then bus {0x00500093 (addi x1,x0,5), pc 0x0}: next cycle valid=1, pc=0, rd=1, imm=5, opcode=0010011, rs1_val=0.
- WB writes x1=0xDEADBEEF while decode holds `add x3,x1,x1` (0x001081B3): rs1_val=rs2_val=0xDEADBEEF in the same cycle. A write to x0 with 0x1234 reads back 0.
- exe_valid=1, exe_is_load=1, exe_rd=2, decode holds `add x4,x2,x0`: stall_flag=1 for one cycle, bubble out, IF/ID holds. The next cycle issues valid=1. The same case with `lui x2,1` gives no stall.
- Stall and flush asserted together: IF/ID cleared, stall_flag=0, next bundle valid=0.
- Decode 0x00000073: ecall_flag=1 for that cycle. The same instruction with flush=1 gives ecall_flag=0.
- Immediate checks:
  - `beq x0,x0,-4` (0xFE000EE3): imm=0xFFFFFFFC.
  - `jal x1,2048` (0x001000EF): imm=0x00000800.
  - `sw x1,-1(x2)` (0xFE112FA3): imm=0xFFFFFFFF.
